// File: rtl/sd_crc7_pkg.sv
// Shared SD-line constants and the CRC7 single-bit update step.
package sd_crc7_pkg;

  localparam int unsigned CRC7_WIDTH = 7;
  localparam logic [CRC7_WIDTH-1:0] CRC7_POLY = 7'h09;
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  // One MSB-first accumulate step; x^7 term is implicit in the shift-out of bit 6.
  function automatic logic [CRC7_WIDTH-1:0] crc7_step(input logic [CRC7_WIDTH-1:0] crc,
                                                      input logic                  din,
                                                      input logic [CRC7_WIDTH-1:0] poly);
    logic fb;
    fb = din ^ crc[CRC7_WIDTH-1];
    return {crc[CRC7_WIDTH-2:0], 1'b0} ^ (fb ? poly : '0);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Bit-serial CRC7 for the SD CMD line: accumulates command/response bits, then shifts the CRC out.
module sd_crc7
  import sd_crc7_pkg::*;
#(
  parameter logic [CRC7_WIDTH-1:0] POLY = CRC7_POLY,
  parameter logic [CRC7_WIDTH-1:0] INIT = 7'h00
) (
  input  logic iclk,
  input  logic irst,
  input  logic idata,
  input  logic iunload,
  output logic ocrc
);

  logic [CRC7_WIDTH-1:0] crc_reg;
  logic [CRC7_WIDTH-1:0] crc_next;

  // Unloading shifts zeros in, so the register is empty after seven unload cycles.
  always_comb begin
    crc_next = crc_reg;
    if (iunload) begin
      crc_next = {crc_reg[CRC7_WIDTH-2:0], 1'b0};
    end else begin
      crc_next = crc7_step(crc_reg, idata, POLY);
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      crc_reg <= INIT;
    end else begin
      crc_reg <= crc_next;
    end
  end

  assign ocrc = crc_reg[CRC7_WIDTH-1];

endmodule

// File: tb/tb_sd_crc7.sv
// Self-checking bench for sd_crc7: directed SD frames plus random mode/reset mixes vs a division model.
module tb_sd_crc7;

  logic iclk;
  logic irst;
  logic idata;
  logic iunload;
  logic ocrc;

  int n_vec;
  int n_err;

  // Reference: register = (start * x^n + M(x) * x^7) mod G(x), G = x^7 + x^3 + 1.
  logic [6:0]      mdl;
  logic [6:0]      acc_r0;
  longint unsigned acc_m;
  int              acc_n;

  sd_crc7 dut (
    .iclk   (iclk),
    .irst   (irst),
    .idata  (idata),
    .iunload(iunload),
    .ocrc   (ocrc)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  function automatic logic [6:0] polymod(input longint unsigned v);
    longint unsigned r;
    r = v;
    for (int i = 63; i >= 7; i--) begin
      if (r[i]) r = r ^ (64'h89 << (i - 7));
    end
    return r[6:0];
  endfunction

  task automatic restart_segment();
    acc_r0 = mdl;
    acc_m  = 0;
    acc_n  = 0;
  endtask

  task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock with the given controls, then model update and output/state check.
  task automatic step(input logic rst, input logic unl, input logic d);
    irst    = rst;
    iunload = unl;
    idata   = d;
    @(posedge iclk);
    #1;
    if (rst) begin
      mdl = 7'h00;
      restart_segment();
    end else if (unl) begin
      mdl = {mdl[5:0], 1'b0};
      restart_segment();
    end else begin
      acc_m = (acc_m << 1) | longint'(d);
      acc_n++;
      mdl = polymod((longint'(acc_r0) << acc_n) ^ (acc_m << 7));
      if (acc_n == 50) restart_segment();
    end
    check_bit("ocrc", ocrc, mdl[6]);
    check_val("crc_reg", dut.crc_reg, mdl);
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 39; i >= 0; i--) step(1'b0, 1'b0, f[i]);
  endtask

  task automatic send_bits(input logic [39:0] f, input int nbits);
    for (int i = 39; i > 39 - nbits; i--) step(1'b0, 1'b0, f[i]);
  endtask

  // idata is randomized during unload since the design must ignore it.
  task automatic unload(input int cycles, output logic [6:0] c);
    c = 7'h00;
    for (int k = 0; k < cycles; k++) begin
      c = {c[5:0], ocrc};
      step(1'b0, 1'b1, 1'($urandom));
    end
  endtask

  logic [6:0]  got;
  logic [39:0] frame;

  initial begin
    n_vec   = 0;
    n_err   = 0;
    mdl     = 7'h00;
    restart_segment();
    irst    = 1'b1;
    iunload = 1'b1;
    idata   = 1'b1;

    // Reset state
    step(1'b1, 1'b1, 1'b1);
    check_bit("reset_ocrc", ocrc, 1'b0);

    // CMD0
    send_frame(40'h40_0000_0000);
    unload(7, got);
    check_val("cmd0_crc", got, 7'h4A);

    // CMD8
    step(1'b1, 1'b0, 1'b0);
    send_frame(40'h48_0000_01AA);
    unload(7, got);
    check_val("cmd8_crc", got, 7'h43);

    // CMD17
    step(1'b1, 1'b0, 1'b0);
    send_frame(40'h51_0000_0000);
    unload(7, got);
    check_val("cmd17_crc", got, 7'h2A);

    // R1 response and a single-bit corruption
    step(1'b1, 1'b0, 1'b0);
    send_frame(40'h11_0000_0900);
    unload(7, got);
    check_val("r1_crc", got, 7'h33);
    step(1'b1, 1'b0, 1'b0);
    frame = 40'h11_0000_0900 ^ (40'h1 << $urandom_range(39, 0));
    send_frame(frame);
    unload(7, got);
    n_vec++;
    assert (got !== 7'h33)
    else begin
      n_err++;
      $error("FAIL r1_flip observed=%h required_not=%h", got, 7'h33);
    end

    // Zero stream stays zero; over-unload keeps ocrc low
    step(1'b1, 1'b0, 1'b0);
    send_frame(40'h00_0000_0000);
    check_val("zero_stream", dut.crc_reg, 7'h00);
    send_frame(40'h48_0000_01AA);
    unload(10, got);
    check_bit("over_unload", ocrc, 1'b0);

    // Back-to-back without reset
    step(1'b1, 1'b0, 1'b0);
    send_frame(40'h40_0000_0000);
    unload(7, got);
    check_val("b2b_first", got, 7'h4A);
    check_val("b2b_clear", dut.crc_reg, 7'h00);
    send_frame(40'h48_0000_01AA);
    unload(7, got);
    check_val("b2b_second", got, 7'h43);

    // Reset priority mid-accumulate and mid-unload
    send_bits(40'h48_0000_01AA, 21);
    step(1'b1, 1'b0, 1'b1);
    check_bit("rst_mid_acc", ocrc, 1'b0);
    send_frame(40'h51_0000_0000);
    unload(3, got);
    step(1'b1, 1'b1, 1'b0);
    check_val("rst_mid_unl", dut.crc_reg, 7'h00);
    send_frame(40'h40_0000_0000);
    unload(7, got);
    check_val("rst_then_cmd0", got, 7'h4A);

    // Random mode switching, reset injection and data
    for (int i = 0; i < 600; i++) begin
      int sel;
      sel = int'($urandom_range(19, 0));
      if (sel == 0) step(1'b1, 1'($urandom), 1'($urandom));
      else if (sel < 7) step(1'b0, 1'b1, 1'($urandom));
      else step(1'b0, 1'b0, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
